// File: rtl/ad9228_multi_ch_trig_capture.sv
// Triggered pre/post-trigger window capture of packed AD9228 channel samples into one
// circular RAM, streamed out over valid/ready once the window is complete.
//
// state   | meaning
// IDLE    | waiting for arm
// PREFILL | collecting pre-trigger history, triggers ignored
// ARMED   | circular recording, every valid sample tested for a trigger
// POST    | recording the remaining post-trigger samples
// READOUT | streaming the window out, incoming samples discarded

module ad9228_multi_ch_trig_capture #(
    parameter int  NUM_CH     = 4,
    parameter int  DATA_WIDTH = 12,
    parameter int  DEPTH      = 2048,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int W          = NUM_CH * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sample_valid,
    input  logic [W-1:0]          sample_data,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [AW-1:0]         pre_len,
    input  logic [AW:0]           post_len,
    input  logic [1:0]            trig_mode,
    input  logic [CW-1:0]         trig_ch,
    input  logic [DATA_WIDTH-1:0] trig_thr,
    input  logic                  sw_trig,
    input  logic                  ext_trig,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE, S_PREFILL, S_ARMED, S_POST, S_READOUT
    } state_t;

    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);

    state_t state, state_nxt;

    logic [W-1:0]          mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           fill_cnt;
    logic [AW:0]           issue_cnt;
    logic [AW-1:0]         pre_r;
    logic [AW:0]           post_r;
    logic [DATA_WIDTH-1:0] prev;
    logic                  prev_valid;

    logic [DATA_WIDTH-1:0] chans [NUM_CH];
    logic [DATA_WIDTH-1:0] cur;
    logic                  thr_hit;
    logic                  arm_go;
    logic                  wr_en;
    logic                  trig_fire;
    logic                  prefill_last;
    logic                  post_last;
    logic                  rd_en;
    logic                  last_hs;
    logic [AW:0]           post_max;
    logic [AW:0]           post_sel;
    logic [AW:0]           post_eff;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            chans[i] = sample_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign cur = chans[trig_ch];

    always_comb begin
        thr_hit = 1'b0;
        case (trig_mode)
            2'b01:   thr_hit = prev_valid && (prev < trig_thr) && (cur >= trig_thr);
            2'b10:   thr_hit = prev_valid && (prev >= trig_thr) && (cur < trig_thr);
            2'b11:   thr_hit = ext_trig;
            default: thr_hit = 1'b0;
        endcase
    end

    // pre_len can never exceed DEPTH-1, so only post needs clamping to fit the RAM.
    assign post_max = DEPTH_W - {1'b0, pre_len};
    assign post_sel = (post_len == '0) ? CNT_ONE : post_len;
    assign post_eff = (post_sel > post_max) ? post_max : post_sel;

    assign arm_go       = arm && !abort && (state == S_IDLE);
    assign wr_en        = sample_valid &&
                          ((state == S_PREFILL) || (state == S_ARMED) || (state == S_POST));
    assign trig_fire    = (state == S_ARMED) && sample_valid && (sw_trig || thr_hit);
    assign prefill_last = (state == S_PREFILL) && sample_valid &&
                          ((fill_cnt + CNT_ONE) == {1'b0, pre_r});
    assign post_last    = (state == S_POST) && sample_valid && ((fill_cnt + CNT_ONE) == post_r);
    assign rd_en        = (state == S_READOUT) && (issue_cnt != '0) && (!out_valid || out_ready);
    assign last_hs      = out_valid && out_ready && out_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (arm_go) begin
                    state_nxt = (pre_len == '0) ? S_ARMED : S_PREFILL;
                end
            end
            S_PREFILL: begin
                if (prefill_last) state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (trig_fire) state_nxt = (post_r == CNT_ONE) ? S_READOUT : S_POST;
            end
            S_POST: begin
                if (post_last) state_nxt = S_READOUT;
            end
            S_READOUT: begin
                if (last_hs) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= sample_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_cnt   <= '0;
            issue_cnt  <= '0;
            pre_r      <= '0;
            post_r     <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            triggered  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                issue_cnt <= '0;
            end else begin
                if (arm_go) begin
                    pre_r      <= pre_len;
                    post_r     <= post_eff;
                    issue_cnt  <= {1'b0, pre_len} + post_eff;
                    wr_ptr     <= '0;
                    fill_cnt   <= '0;
                    prev_valid <= 1'b0;
                    triggered  <= 1'b0;
                end
                if (wr_en) begin
                    wr_ptr     <= wr_ptr + PTR_ONE;
                    prev       <= cur;
                    prev_valid <= 1'b1;
                    if ((state == S_PREFILL) || (state == S_POST)) begin
                        fill_cnt <= fill_cnt + CNT_ONE;
                    end
                end
                // The trigger sample itself is post-sample #1.
                if (trig_fire) begin
                    rd_ptr    <= wr_ptr - pre_r;
                    triggered <= 1'b1;
                    fill_cnt  <= CNT_ONE;
                end
                if (rd_en) begin
                    out_data  <= mem[rd_ptr];
                    rd_ptr    <= rd_ptr + PTR_ONE;
                    issue_cnt <= issue_cnt - CNT_ONE;
                    out_valid <= 1'b1;
                    out_last  <= (issue_cnt == CNT_ONE);
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
                if (last_hs) done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ad9228_multi_ch_trig_capture.sv
// Directed and randomized bench for the triggered capture buffer; expected windows come from
// a sample-index model of the trigger rules applied to the generated input stream.

module tb_ad9228_multi_ch_trig_capture;

    localparam int NUM_CH = 4;
    localparam int DW     = 12;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int W      = NUM_CH * DW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          sample_valid;
    logic [W-1:0]  sample_data;
    logic          arm;
    logic          abort;
    logic [AW-1:0] pre_len;
    logic [AW:0]   post_len;
    logic [1:0]    trig_mode;
    logic [1:0]    trig_ch;
    logic [DW-1:0] trig_thr;
    logic          sw_trig;
    logic          ext_trig;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          busy;
    logic          triggered;
    logic          done;

    always #5 clk = ~clk;

    ad9228_multi_ch_trig_capture #(
        .NUM_CH    (NUM_CH),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .sample_valid(sample_valid),
        .sample_data (sample_data),
        .arm         (arm),
        .abort       (abort),
        .pre_len     (pre_len),
        .post_len    (post_len),
        .trig_mode   (trig_mode),
        .trig_ch     (trig_ch),
        .trig_thr    (trig_thr),
        .sw_trig     (sw_trig),
        .ext_trig    (ext_trig),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .triggered   (triggered),
        .done        (done)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [W-1:0] stream [$];
    bit           sw_s   [$];
    bit           ext_s  [$];
    logic [W-1:0] exp_q  [$];
    int           trig_idx;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] ch_of(input logic [W-1:0] w, input int c);
        return w[c*DW +: DW];
    endfunction

    function automatic int eff_post(input int pre, input int post_req);
        int p;
        p = (post_req == 0) ? 1 : post_req;
        if (p > DEPTH - pre) p = DEPTH - pre;
        return p;
    endfunction

    function automatic logic [W-1:0] rand_word();
        return {$urandom(), $urandom()};
    endfunction

    task automatic clear_stream();
        stream.delete();
        sw_s.delete();
        ext_s.delete();
    endtask

    // Window = the pre samples before the first qualifying sample at index >= pre, plus post from it.
    task automatic model(input int pre, input int post_req, input int mode, input int ch, input int thr);
        int  post;
        bit  hit;
        post     = eff_post(pre, post_req);
        trig_idx = -1;
        for (int k = pre; k < stream.size() && trig_idx < 0; k++) begin
            hit = sw_s[k];
            if (mode == 3 && ext_s[k]) hit = 1'b1;
            if (k > 0 && mode == 1 && ch_of(stream[k-1], ch) < DW'(thr) &&
                ch_of(stream[k], ch) >= DW'(thr)) hit = 1'b1;
            if (k > 0 && mode == 2 && ch_of(stream[k-1], ch) >= DW'(thr) &&
                ch_of(stream[k], ch) < DW'(thr)) hit = 1'b1;
            if (hit) trig_idx = k;
        end
        exp_q.delete();
        if (trig_idx >= 0 && trig_idx + post <= stream.size()) begin
            for (int j = 0; j < pre + post; j++) exp_q.push_back(stream[trig_idx - pre + j]);
        end else begin
            $fatal(1, "bench stream has no complete window");
        end
    endtask

    task automatic do_arm(input int pl, input int ql, input int mode, input int ch, input int thr);
        @(negedge clk);
        pre_len      = AW'(pl);
        post_len     = (AW+1)'(ql);
        trig_mode    = 2'(mode);
        trig_ch      = 2'(ch);
        trig_thr     = DW'(thr);
        sample_valid = 1'b0;
        sw_trig      = 1'b0;
        ext_trig     = 1'b0;
        arm          = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check("busy_after_arm", busy, 1);
        check("trig_clear_at_arm", triggered, 0);
    endtask

    // Gap cycles carry random trigger levels that must not be evaluated.
    task automatic feed(input int n, input int gap_pct);
        for (int k = 0; k < n; k++) begin
            for (int g = 0; g < 3 && $urandom_range(0, 99) < gap_pct; g++) begin
                @(negedge clk);
                sample_valid = 1'b0;
                sample_data  = rand_word();
                sw_trig      = 1'($urandom());
                ext_trig     = 1'($urandom());
            end
            @(negedge clk);
            sample_valid = 1'b1;
            sample_data  = stream[k];
            sw_trig      = sw_s[k];
            ext_trig     = ext_s[k];
        end
        @(negedge clk);
        sample_valid = 1'b0;
        sw_trig      = 1'b0;
        ext_trig     = 1'b0;
    endtask

    task automatic collect(input int ready_pct, input int stop_after);
        int           idx   = 0;
        int           cyc   = 0;
        int           first = -1;
        int           lastc = 0;
        int           n;
        int           want;
        bit           stalled = 1'b0;
        bit           rdy;
        logic [W-1:0] hd = '0;
        logic         hl = 1'b0;
        n    = exp_q.size();
        want = (stop_after < n) ? stop_after : n;
        while (idx < want && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, hd);
                check("stall_last", out_last, hl);
            end
            rdy       = ($urandom_range(0, 99) < ready_pct);
            out_ready = rdy;
            if (out_valid && rdy) begin
                check("data", out_data, exp_q[idx]);
                check("last", out_last, (idx == n - 1));
                if (first < 0) first = cyc;
                lastc = cyc;
                idx++;
            end
            stalled = out_valid && !rdy;
            hd      = out_data;
            hl      = out_last;
        end
        check("words_seen", idx, want);
        if (ready_pct == 100 && want == n) check("throughput", lastc - first, n - 1);
        if (want == n) begin
            @(negedge clk);
            out_ready = 1'b0;
            check("done_pulse", done, 1);
            check("valid_after_last", out_valid, 0);
            check("idle_after_last", busy, 0);
            @(negedge clk);
            check("done_one_cycle", done, 0);
        end else begin
            @(negedge clk);
            abort     = 1'b1;
            out_ready = 1'b0;
            @(negedge clk);
            abort = 1'b0;
            check("abort_ro_idle", busy, 0);
            check("abort_ro_valid", out_valid, 0);
            check("abort_ro_done", done, 0);
            @(negedge clk);
            check("abort_ro_no_done", done, 0);
        end
    endtask

    task automatic run(input int pl, input int ql, input int mode, input int ch, input int thr,
                       input int gap_pct, input int ready_pct);
        model(pl, ql, mode, ch, thr);
        do_arm(pl, ql, mode, ch, thr);
        feed(stream.size(), gap_pct);
        check("triggered", triggered, 1);
        collect(ready_pct, 1 << 30);
    endtask

    initial begin
        int pre;
        int ql;
        int post;
        int extra;
        int len;
        int tp;
        rstn = 1'b0; sample_valid = 1'b0; sample_data = '0; arm = 1'b0; abort = 1'b0;
        pre_len = '0; post_len = '0; trig_mode = 2'b00; trig_ch = 2'd0; trig_thr = '0;
        sw_trig = 1'b0; ext_trig = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_trig", triggered, 0);
        check("rst_done", done, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 0);

        // Ramp on all channels, software trigger on sample 10: window 6..13.
        clear_stream();
        for (int k = 0; k < 20; k++) begin
            stream.push_back({4{DW'(k)}});
            sw_s.push_back(k == 10);
            ext_s.push_back(1'b0);
        end
        model(4, 4, 0, 0, 0);
        check("ramp_model_first", exp_q[0], {4{DW'(6)}});
        do_arm(4, 4, 0, 0, 0);
        feed(stream.size(), 0);
        check("triggered_ramp", triggered, 1);
        collect(100, 1 << 30);

        // Rising threshold on ch2 at sample 20.
        clear_stream();
        for (int k = 0; k < 30; k++) begin
            logic [W-1:0] w;
            w = rand_word();
            w[2*DW +: DW] = (k < 20) ? DW'(12'h7FF) : ((k == 20) ? DW'(12'h800) : DW'($urandom()));
            stream.push_back(w);
            sw_s.push_back(1'b0);
            ext_s.push_back(1'($urandom()));
        end
        run(5, 6, 1, 2, 12'h800, 30, 70);

        // post clamps to DEPTH-pre and start pointer wraps.
        clear_stream();
        for (int k = 0; k < 30; k++) begin
            stream.push_back(rand_word());
            sw_s.push_back(k == 22);
            ext_s.push_back(1'b0);
        end
        run(12, 10, 0, 0, 0, 20, 100);

        // Random configurations and backpressure.
        for (int it = 0; it < 8; it++) begin
            pre   = $urandom_range(0, DEPTH - 1);
            ql    = $urandom_range(0, 2 * DEPTH - 1);
            post  = eff_post(pre, ql);
            extra = $urandom_range(0, 20);
            len   = pre + extra + post + 2;
            clear_stream();
            for (int k = 0; k < len; k++) begin
                stream.push_back(rand_word());
                sw_s.push_back(($urandom_range(0, 99) < 3) || (k == pre + extra));
                ext_s.push_back($urandom_range(0, 99) < 10);
            end
            run(pre, ql, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4095), 25, 40);
        end

        // Abort during POST, with a simultaneous arm that must be ignored.
        clear_stream();
        for (int k = 0; k < 20; k++) begin
            stream.push_back(rand_word());
            sw_s.push_back(k == 6);
            ext_s.push_back(1'b0);
        end
        tp = 6;
        do_arm(3, 8, 0, 0, 0);
        feed(tp + 3, 20);
        check("post_busy", busy, 1);
        check("post_triggered", triggered, 1);
        abort = 1'b1;
        arm   = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        arm   = 1'b0;
        check("abort_post_idle", busy, 0);
        check("abort_post_valid", out_valid, 0);
        check("abort_post_done", done, 0);
        @(negedge clk);
        check("abort_post_stays_idle", busy, 0);
        arm   = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        arm   = 1'b0;
        abort = 1'b0;
        check("arm_with_abort_ignored", busy, 0);
        run(3, 8, 0, 0, 0, 20, 60);

        // Abort mid-readout, then a clean capture.
        model(5, 9, 0, 0, 0);
        do_arm(5, 9, 0, 0, 0);
        feed(stream.size(), 10);
        collect(60, 5);
        run(5, 9, 0, 0, 0, 10, 60);

        // pre=0, post=1, ext_trig on the very first sample.
        clear_stream();
        for (int k = 0; k < 4; k++) begin
            stream.push_back(rand_word());
            sw_s.push_back(1'b0);
            ext_s.push_back(k == 0);
        end
        run(0, 1, 3, 0, 0, 0, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
